mc_control_fsm: RTL and testbench

- Multicycle MIPS-subset control unit; the stage directly upstream of the ALU B-operand mux.
- Moore-style FSM with mem_ready-qualified memory states.
- Drives every datapath select and enable, including the 4-bit ALUSrcB selector, whose codes are 0000 B, 0001 const 4, 0010 SignExt, 0011 Shift2.
- Supports R-type, addi, lw, sw, beq and j.
- Counts retired instructions.

---
 rtl/mc_control_fsm_if.sv | 50 +++++
 rtl/mc_control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control-unit bus between the multicycle FSM and its datapath
//
// Purpose: bundles the opcode/memory-handshake inputs and every datapath
// select/enable driven by mc_control_fsm.
// Ports (signals):
//   opcode[5:0], mem_ready            : datapath -> FSM
//   pc_write, pc_write_cond, i_or_d,
//   mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b[3:0],
//   alu_op[1:0], pc_source[1:0]       : FSM -> datapath controls
//   state_out[3:0], illegal_op,
//   instr_count[CNT_W-1:0]            : FSM status
// Modports: master = FSM side, slave = datapath side.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [3:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state_out;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state_out, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state_out, illegal_op, instr_count
    );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS-subset control FSM with retired-instruction counter
//
// Purpose: Moore control unit for R-type, addi, lw, sw, beq and j. Memory
// states wait on mem_ready; FETCH's ir_write/pc_write follow mem_ready.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mc_control_fsm_if.master (opcode/mem_ready in, controls and
//              status out)
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    mc_control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LW_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_instr_count;

    logic       w_illegal_set;
    logic       w_retire;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [3:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_illegal_op  <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state      <= w_next;
            r_illegal_op <= w_illegal_set;
            if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        w_illegal_set   = 1'b0;
        w_retire        = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 4'b0000;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 4'b0001;
                // IR and PC latch only on the cycle the fetch completes
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 4'b0011;
                case (bus.opcode)
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_ADDI:      w_next = S_EXEC_I;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next        = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 4'b0010;
                if (bus.opcode == OP_LW) begin
                    w_next = S_MEM_RD;
                end else if (bus.opcode == OP_SW) begin
                    w_next = S_MEM_WR;
                end else begin
                    // IR changed under us: abandon rather than guess
                    w_next = S_FETCH;
                end
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_LW_WB;
                end
            end
            S_LW_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 4'b0010;
                w_next      = S_I_WB;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_retire        = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Controls are gated by reset_n so nothing is enabled while reset is low,
    // even though FETCH itself would otherwise request a read.
    assign bus.pc_write      = reset_n & w_pc_write;
    assign bus.pc_write_cond = reset_n & w_pc_write_cond;
    assign bus.i_or_d        = reset_n & w_i_or_d;
    assign bus.mem_read      = reset_n & w_mem_read;
    assign bus.mem_write     = reset_n & w_mem_write;
    assign bus.ir_write      = reset_n & w_ir_write;
    assign bus.reg_dst       = reset_n & w_reg_dst;
    assign bus.mem_to_reg    = reset_n & w_mem_to_reg;
    assign bus.reg_write     = reset_n & w_reg_write;
    assign bus.alu_src_a     = reset_n & w_alu_src_a;
    assign bus.alu_src_b     = reset_n ? w_alu_src_b : 4'b0000;
    assign bus.alu_op        = reset_n ? w_alu_op    : 2'b00;
    assign bus.pc_source     = reset_n ? w_pc_source : 2'b00;
    assign bus.state_out     = r_state;
    assign bus.illegal_op    = r_illegal_op;
    assign bus.instr_count   = r_instr_count;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;
    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[3:0],
    //  alu_op[1:0], pc_source[1:0]}
    localparam logic [17:0] C_ZERO       = 18'b0_0_0_0_0_0_0_0_0_0_0000_00_00;
    localparam logic [17:0] C_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_0001_00_00;
    localparam logic [17:0] C_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_0001_00_00;
    localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_0011_00_00;
    localparam logic [17:0] C_MEM_ADDR   = 18'b0_0_0_0_0_0_0_0_0_1_0010_00_00;
    localparam logic [17:0] C_MEM_RD     = 18'b0_0_1_1_0_0_0_0_0_0_0000_00_00;
    localparam logic [17:0] C_LW_WB      = 18'b0_0_0_0_0_0_0_1_1_0_0000_00_00;
    localparam logic [17:0] C_MEM_WR     = 18'b0_0_1_0_1_0_0_0_0_0_0000_00_00;
    localparam logic [17:0] C_EXEC_R     = 18'b0_0_0_0_0_0_0_0_0_1_0000_10_00;
    localparam logic [17:0] C_R_WB       = 18'b0_0_0_0_0_0_1_0_1_0_0000_00_00;
    localparam logic [17:0] C_EXEC_I     = 18'b0_0_0_0_0_0_0_0_0_1_0010_00_00;
    localparam logic [17:0] C_I_WB       = 18'b0_0_0_0_0_0_0_0_1_0_0000_00_00;
    localparam logic [17:0] C_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_0000_01_01;
    localparam logic [17:0] C_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_0000_00_10;

    typedef struct {
        string       lbl;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic        ill;
        logic [3:0]  cnt;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t q[$];
    logic [CNT_W-1:0] exp_cnt;
    int checks;
    int errors;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    // Monitor: samples away from the rising edge, and also just after an
    // asynchronous reset assertion.
    initial begin
        exp_t        e;
        logic [17:0] a_ctl;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk or negedge reset_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                         bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                         bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                         bus.pc_source};
                checks++;
                if (bus.state_out !== e.st || a_ctl !== e.ctl ||
                    bus.illegal_op !== e.ill || bus.instr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got state=%0d ctl=%b ill=%b cnt=%0d, required state=%0d ctl=%b ill=%b cnt=%0d",
                             e.lbl, bus.state_out, a_ctl, bus.illegal_op, bus.instr_count,
                             e.st, e.ctl, e.ill, e.cnt);
                end
            end
        end
    end

    task automatic push(input string lbl, input logic [3:0] st, input logic [17:0] ctl,
                        input logic ill);
        exp_t e;
        e.lbl = lbl;
        e.st  = st;
        e.ctl = ctl;
        e.ill = ill;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    task automatic step(input string lbl, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [17:0] ctl, input logic ill);
        bus.opcode    = op;
        bus.mem_ready = mr;
        push(lbl, st, ctl, ill);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b1;
        exp_cnt       = '0;
        @(posedge clk);
        #1;

        // reset held low: FETCH, every control 0 despite mem_ready
        step("rst_low", OP_R, 1'b1, 4'd0, C_ZERO, 1'b0);
        reset_n = 1'b1;
        step("rel_fetch", OP_R, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("r0_decode", OP_R, 1'b1, 4'd1, C_DECODE, 1'b0);

        // asynchronous reset in the middle of EXEC_R
        push("r0_exec", 4'd6, C_EXEC_R, 1'b0);
        @(negedge clk);
        #2;
        push("rst_async", 4'd0, C_ZERO, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        step("rst_hold", OP_R, 1'b1, 4'd0, C_ZERO, 1'b0);
        reset_n = 1'b1;

        // R-type: 0,1,6,7
        step("r_fetch",  OP_R, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("r_decode", OP_R, 1'b1, 4'd1, C_DECODE, 1'b0);
        step("r_exec",   OP_R, 1'b1, 4'd6, C_EXEC_R, 1'b0);
        step("r_wb",     OP_R, 1'b1, 4'd7, C_R_WB, 1'b0);
        exp_cnt++;

        // lw with three stall cycles in MEM_RD
        step("lw_fetch",  OP_LW, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("lw_decode", OP_LW, 1'b1, 4'd1, C_DECODE, 1'b0);
        step("lw_addr",   OP_LW, 1'b1, 4'd2, C_MEM_ADDR, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("lw_stall", OP_LW, 1'b0, 4'd3, C_MEM_RD, 1'b0);
        end
        step("lw_rd",     OP_LW, 1'b1, 4'd3, C_MEM_RD, 1'b0);
        step("lw_wb",     OP_LW, 1'b1, 4'd4, C_LW_WB, 1'b0);
        exp_cnt++;

        // sw with a fetch stall and a write stall
        step("sw_fwait",  OP_SW, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);
        step("sw_fetch",  OP_SW, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("sw_decode", OP_SW, 1'b1, 4'd1, C_DECODE, 1'b0);
        step("sw_addr",   OP_SW, 1'b1, 4'd2, C_MEM_ADDR, 1'b0);
        step("sw_stall",  OP_SW, 1'b0, 4'd5, C_MEM_WR, 1'b0);
        step("sw_wr",     OP_SW, 1'b1, 4'd5, C_MEM_WR, 1'b0);
        exp_cnt++;

        // beq
        step("beq_fetch",  OP_BEQ, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("beq_decode", OP_BEQ, 1'b1, 4'd1, C_DECODE, 1'b0);
        step("beq_branch", OP_BEQ, 1'b1, 4'd10, C_BRANCH, 1'b0);
        exp_cnt++;

        // j
        step("j_fetch",  OP_J, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("j_decode", OP_J, 1'b1, 4'd1, C_DECODE, 1'b0);
        step("j_jump",   OP_J, 1'b1, 4'd11, C_JUMP, 1'b0);
        exp_cnt++;

        // addi, mem_ready low outside memory states must be ignored
        step("addi_fetch",  OP_ADDI, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("addi_decode", OP_ADDI, 1'b0, 4'd1, C_DECODE, 1'b0);
        step("addi_exec",   OP_ADDI, 1'b0, 4'd8, C_EXEC_I, 1'b0);
        step("addi_wb",     OP_ADDI, 1'b0, 4'd9, C_I_WB, 1'b0);
        exp_cnt++;

        // illegal opcode: one-cycle pulse, back to FETCH, count unchanged
        step("il_fetch",  OP_BAD, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
        step("il_decode", OP_BAD, 1'b1, 4'd1, C_DECODE, 1'b0);
        step("il_pulse",  OP_BAD, 1'b0, 4'd0, C_FETCH_WAIT, 1'b1);
        step("il_after",  OP_BAD, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);

        // counter wrap: count is 6 here, ten jumps take it to 15 then 0
        for (int k = 0; k < 10; k++) begin
            step("wrap_fetch",  OP_J, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
            step("wrap_decode", OP_J, 1'b1, 4'd1, C_DECODE, 1'b0);
            step("wrap_jump",   OP_J, 1'b1, 4'd11, C_JUMP, 1'b0);
            exp_cnt++;
        end
        step("cnt_wrap", OP_J, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);

        @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
